// File: rtl/trit_pkg.sv
// rtl/trit_pkg.sv - trit encoding constants and helpers
// Shared by the trit word packer and its sub-modules.
package trit_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_ZERO = 2'b00;
   localparam trit_t TRIT_POS  = 2'b01;
   localparam trit_t TRIT_NEG  = 2'b11;
   localparam trit_t TRIT_AMB  = 2'b10;

   // Numeric weight of a trit; the ambiguous '+/-' code carries no value.
   function automatic logic signed [1:0] trit_to_int(input trit_t t);
      case (t)
         TRIT_POS: trit_to_int = 2'sb01;
         TRIT_NEG: trit_to_int = 2'sb11;
         default:  trit_to_int = 2'sb00;
      endcase
   endfunction

endpackage

// File: rtl/trit_sat_counter.sv
// rtl/trit_sat_counter.sv - saturating up-counter with enable
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset, clears count
//   en    - increment request for this cycle
//   count - current value, holds at all-ones once reached
module trit_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/trit_word_packer.sv
// rtl/trit_word_packer.sv - packs resolved trits into balanced-ternary words
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-low reset
//   in_trit/in_valid     - one resolved trit per accepted cycle
//   in_ready             - combinational: !out_valid || out_ready
//   flush                - emit the partial word (only when in_valid=0)
//   out_word/out_value   - packed trits (first trit in MS slot) and signed value
//   out_len/out_ambig    - valid trit count, word holds an ambiguous trit
//   out_valid/out_ready  - output word handshake
//   amb_count            - saturating count of accepted ambiguous trits
module trit_word_packer
   import trit_pkg::*;
#(
   parameter int WORD_TRITS = 6,
   parameter int VAL_W      = 10,
   parameter int CNT_W      = 8,
   localparam int LW        = $clog2(WORD_TRITS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                in_trit,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   output logic [2*WORD_TRITS-1:0]   out_word,
   output logic signed [VAL_W-1:0]   out_value,
   output logic [LW-1:0]             out_len,
   output logic                      out_ambig,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CNT_W-1:0]          amb_count
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t                    state;
   logic [LW-1:0]             fill;
   logic [2*WORD_TRITS-1:0]   sreg;
   logic signed [VAL_W-1:0]   acc;
   logic                      ambig;

   logic                      accept;
   logic                      is_amb;
   logic                      last;
   logic                      do_flush;
   logic signed [1:0]         tv;
   logic signed [VAL_W-1:0]   acc_next;
   logic [2*WORD_TRITS-1:0]   sreg_next;
   logic [2*WORD_TRITS-1:0]   flush_word;

   assign in_ready  = (state == COLLECT) || out_ready;
   assign out_valid = (state == HOLD);

   always_comb begin
      accept    = in_valid && in_ready;
      is_amb    = (in_trit == TRIT_AMB);
      tv        = trit_to_int(in_trit);
      // acc*3 + t, kept in two's complement at VAL_W bits
      acc_next  = acc + (acc <<< 1) + VAL_W'(tv);
      sreg_next = {sreg[2*WORD_TRITS-3:0], in_trit};
      last      = (fill == LW'(WORD_TRITS - 1));
      do_flush  = flush && !in_valid && (fill != '0) && in_ready;
      // Partial word sits in the LS slots; move it up so the first trit is MS.
      flush_word = sreg << (2 * (WORD_TRITS - 32'(fill)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= COLLECT;
         fill      <= '0;
         sreg      <= '0;
         acc       <= '0;
         ambig     <= 1'b0;
         out_word  <= '0;
         out_value <= '0;
         out_len   <= '0;
         out_ambig <= 1'b0;
      end else if (accept && last) begin
         out_word  <= sreg_next;
         out_value <= acc_next;
         out_len   <= LW'(WORD_TRITS);
         out_ambig <= ambig || is_amb;
         state     <= HOLD;
         fill      <= '0;
         sreg      <= '0;
         acc       <= '0;
         ambig     <= 1'b0;
      end else if (accept) begin
         sreg  <= sreg_next;
         acc   <= acc_next;
         ambig <= ambig || is_amb;
         fill  <= fill + LW'(1);
         // Accepting while holding implies out_ready, so the held word leaves.
         if (state == HOLD) begin
            state <= COLLECT;
         end
      end else if (do_flush) begin
         out_word  <= flush_word;
         out_value <= acc;
         out_len   <= fill;
         out_ambig <= ambig;
         state     <= HOLD;
         fill      <= '0;
         sreg      <= '0;
         acc       <= '0;
         ambig     <= 1'b0;
      end else if ((state == HOLD) && out_ready) begin
         state <= COLLECT;
      end
   end

   trit_sat_counter #(
      .CNT_W (CNT_W)
   ) u_amb_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (accept && is_amb),
      .count (amb_count)
   );

endmodule

// File: tb/tb_trit_word_packer.sv
// tb/tb_trit_word_packer.sv - scoreboard bench for trit_word_packer
module tb_trit_word_packer;

   localparam int WT = 6;
   localparam int VW = 10;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    in_trit = 2'b00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic [11:0]   out_word;
   logic signed [VW-1:0] out_value;
   logic [2:0]    out_len;
   logic          out_ambig;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] amb_count;

   typedef struct {
      logic [11:0] word;
      int          value;
      int          len;
      logic        ambig;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   trit_word_packer #(
      .WORD_TRITS (WT),
      .VAL_W      (VW),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_trit   (in_trit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_word  (out_word),
      .out_value (out_value),
      .out_len   (out_len),
      .out_ambig (out_ambig),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .amb_count (amb_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [11:0] w, input int v, input int l, input logic a);
      exp_t e;
      e.word = w; e.value = v; e.len = l; e.ambig = a;
      q.push_back(e);
   endtask

   // Monitor: every handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got word %h with no expectation", out_word);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_word",  int'(out_word),     int'(e.word));
            check("out_value", int'(out_value),    e.value);
            check("out_len",   int'(out_len),      e.len);
            check("out_ambig", int'(out_ambig),    int'(e.ambig));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the trit was accepted.
   task automatic send(input logic [1:0] t);
      bit ok = 1'b0;
      in_trit  = t;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      bit ok = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("flush_timeout", 0, 1);
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic send_word(input logic [11:0] w);
      logic [11:0] tmp;
      tmp = w;
      for (int i = 0; i < WT; i++) send(tmp[11-2*i -: 2]);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_word",  int'(out_word),  0);
      check("rst_out_value", int'(out_value), 0);
      check("rst_out_len",   int'(out_len),   0);
      check("rst_out_ambig", int'(out_ambig), 0);
      check("rst_amb_count", int'(amb_count), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // All +1: max positive word, one-cycle latency
      push(12'h555, 364, 6, 1'b0);
      send_word(12'h555);
      check("latency_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      check("amb_count_t1", int'(amb_count), 0);

      // Mixed word with one ambiguous trit
      push(12'b01_11_00_10_01_11, 164, 6, 1'b1);
      send_word(12'b01_11_00_10_01_11);
      @(posedge clk); #1;
      check("amb_count_t2", int'(amb_count), 1);

      // Backpressure: all -1 held for 5 cycles
      out_ready = 1'b0;
      push(12'hFFF, -364, 6, 1'b0);
      send_word(12'hFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready",  int'(in_ready),  0);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_word",  int'(out_word),  int'(12'hFFF));
         check("bp_out_value", int'(out_value), -364);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(12'h1D3, 62, 6, 1'b0);
      send_word(12'h1D3);
      @(posedge clk); #1;

      // Flush with nothing collected is ignored
      do_flush();
      @(negedge clk);
      check("empty_flush_valid", int'(out_valid), 0);
      @(posedge clk); #1;

      // Partial-word flush
      push(12'hF40, -11, 3, 1'b0);
      send(2'b11); send(2'b11); send(2'b01);
      do_flush();
      @(posedge clk); #1;

      // Asynchronous reset mid-word
      send(2'b01); send(2'b11); send(2'b01); send(2'b11);
      #3;
      rst = 1'b0;
      #1;
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_out_word",  int'(out_word),  0);
      check("arst_out_value", int'(out_value), 0);
      check("arst_out_len",   int'(out_len),   0);
      check("arst_amb_count", int'(amb_count), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      push(12'h400, 243, 6, 1'b0);
      send_word(12'h400);
      @(posedge clk); #1;

      // Counter saturation at 7 with 10 ambiguous trits
      push(12'hAAA, 0, 6, 1'b1);
      push(12'hAA0, 0, 4, 1'b1);
      for (int i = 0; i < 10; i++) send(2'b10);
      do_flush();
      check("amb_count_sat", int'(amb_count), 7);

      // Drain
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
